// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, ctrl bit positions and frame constants.
// Imported by the receiver and any sibling UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_TX_SENDING = 1;
  localparam int CTRL_RX_ACK     = 1;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Countdown loaded on start detection to land on the middle of the start bit.
  function automatic logic [15:0] half_reload(input int clks_per_bit);
    int half;
    half = (clks_per_bit - 1) / 2;
    return (half == 0) ? 16'd0 : 16'(half - 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Flops power up to RESET_VAL so an idle-high line does not look like an edge.
module uart_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, holding register with valid/ack
// handshake and sticky frame-error / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin,
  input  logic [7:0] ctrl,
  output logic [7:0] data,
  output logic       state_rx_valid,
  output logic       state_rx_busy,
  output logic       state_rx_frame_err,
  output logic       state_rx_overrun
);

  localparam int          HALF        = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD = half_reload(CLKS_PER_BIT);
  localparam logic [2:0]  LAST_IDX    = 3'(DATA_BITS - 1);

  logic rx_s;
  logic en;
  logic ack;
  logic unused_ctrl;

  uart_state_e state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt;
  logic        frame_err_nxt;
  logic        overrun_nxt;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pin),
    .q    (rx_s)
  );

  assign en          = ctrl[CTRL_EN];
  assign ack         = ctrl[CTRL_RX_ACK];
  assign unused_ctrl = ^ctrl[7:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      state_rx_busy <= 1'b0;
    end else begin
      state         <= state_nxt;
      state_rx_busy <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt                <= '0;
      idx                <= '0;
      shift              <= '0;
      data               <= '0;
      state_rx_valid     <= 1'b0;
      state_rx_frame_err <= 1'b0;
      state_rx_overrun   <= 1'b0;
    end else begin
      cnt                <= cnt_nxt;
      idx                <= idx_nxt;
      shift              <= shift_nxt;
      data               <= data_nxt;
      state_rx_valid     <= valid_nxt;
      state_rx_frame_err <= frame_err_nxt;
      state_rx_overrun   <= overrun_nxt;
    end
  end

  // Ack clears first so that any flag raised by this cycle's stop sample wins.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    shift_nxt     = shift;
    data_nxt      = data;
    valid_nxt     = state_rx_valid;
    frame_err_nxt = state_rx_frame_err;
    overrun_nxt   = state_rx_overrun;

    if (ack) begin
      valid_nxt     = 1'b0;
      frame_err_nxt = 1'b0;
      overrun_nxt   = 1'b0;
    end

    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_s == START_LVL) begin
            idx_nxt = '0;
            if (HALF == 0) begin
              state_nxt = DATA;
              cnt_nxt   = BIT_RELOAD;
            end else begin
              state_nxt = START;
              cnt_nxt   = HALF_RELOAD;
            end
          end
        end

        START: begin
          if (cnt == 16'd0) begin
            if (rx_s == START_LVL) begin
              state_nxt = DATA;
              cnt_nxt   = BIT_RELOAD;
              idx_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end

        DATA: begin
          if (cnt == 16'd0) begin
            shift_nxt[idx] = rx_s;
            cnt_nxt        = BIT_RELOAD;
            if (idx == LAST_IDX) begin
              state_nxt = STOP;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end

        STOP: begin
          if (cnt == 16'd0) begin
            if (rx_s == STOP_LVL) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
              if (state_rx_valid && !ack) begin
                overrun_nxt = 1'b1;
              end
              state_nxt = IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_HIGH;
            end
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end

        // A held-low line (break) must return high before a new start can be seen.
        WAIT_HIGH: begin
          if (rx_s == STOP_LVL) begin
            state_nxt = IDLE;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: one instance at CLKS_PER_BIT=1 and one at 16,
// with expected bytes pushed to a scoreboard queue as frames are driven.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       pin1, pin16;
  logic [7:0] ctrl1, ctrl16;
  logic [7:0] data1, data16;
  logic       valid1, busy1, ferr1, ovr1;
  logic       valid16, busy16, ferr16, ovr16;

  int         errors;
  int         checks;
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk               (clk),
    .reset             (reset),
    .pin               (pin1),
    .ctrl              (ctrl1),
    .data              (data1),
    .state_rx_valid    (valid1),
    .state_rx_busy     (busy1),
    .state_rx_frame_err(ferr1),
    .state_rx_overrun  (ovr1)
  );

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk               (clk),
    .reset             (reset),
    .pin               (pin16),
    .ctrl              (ctrl16),
    .data              (data16),
    .state_rx_valid    (valid16),
    .state_rx_busy     (busy16),
    .state_rx_frame_err(ferr16),
    .state_rx_overrun  (ovr16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [7:0] obs);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      last_good = exp;
      check_output(tag, obs, exp);
    end
  endtask

  // Drives len cycles of a 16-clock-per-bit frame on pin16, starting at a negedge.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_lvl,
                                input int ack_at, input int len);
    int slot;
    for (int c = 0; c < len; c++) begin
      slot = c / 16;
      if (slot == 0) pin16 = 1'b0;
      else if (slot <= 8) pin16 = b[slot-1];
      else pin16 = stop_lvl;
      ctrl16 = (c == ack_at) ? 8'h03 : 8'h01;
      @(negedge clk);
    end
    ctrl16 = 8'h01;
  endtask

  task automatic ack_pulse16();
    ctrl16 = 8'h03;
    @(negedge clk);
    ctrl16 = 8'h01;
  endtask

  initial begin
    logic [9:0] fr;
    errors    = 0;
    checks    = 0;
    last_good = 8'h00;
    reset     = 1'b0;
    pin1      = 1'b1;
    pin16     = 1'b1;
    ctrl1     = 8'h01;
    ctrl16    = 8'h01;

    #1;
    check_output("reset_data", data16, 8'h00);
    check_output("reset_valid", valid16, 8'h00);
    check_output("reset_busy", busy16, 8'h00);
    check_output("reset_flags", {6'b0, ferr16, ovr16}, 8'h00);
    check_output("reset_data1", data1, 8'h00);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    $display("[TB] fast instance: single frame A5");

    fr = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(8'hA5);
    for (int k = 0; k <= 12; k++) begin
      pin1 = (k < 10) ? fr[k] : 1'b1;
      if (k == 2) check_output("fast_busy_detect", busy1, 8'h00);
      if (k == 3) check_output("fast_busy_first", busy1, 8'h01);
      if (k == 11) begin
        check_output("fast_busy_stop", busy1, 8'h01);
        check_output("fast_valid_early", valid1, 8'h00);
      end
      if (k == 12) begin
        check_output("fast_valid", valid1, 8'h01);
        check_data("fast_data", data1);
        check_output("fast_busy_done", busy1, 8'h00);
        check_output("fast_ferr", ferr1, 8'h00);
      end
      @(negedge clk);
    end

    $display("[TB] slow instance: back-to-back 3C, C3 without ack");
    exp_q.push_back(8'h3C);
    apply_stimulus(8'h3C, 1'b1, -1, 160);
    check_data("b2b_data_first", data16);
    check_output("b2b_valid_first", valid16, 8'h01);
    check_output("b2b_ovr_first", ovr16, 8'h00);
    exp_q.push_back(8'hC3);
    apply_stimulus(8'hC3, 1'b1, -1, 160);
    pin16 = 1'b1;
    repeat (4) @(negedge clk);
    check_data("b2b_data_second", data16);
    check_output("b2b_valid", valid16, 8'h01);
    check_output("b2b_overrun", ovr16, 8'h01);
    check_output("b2b_ferr", ferr16, 8'h00);
    ack_pulse16();
    check_output("ack_valid", valid16, 8'h00);
    check_output("ack_overrun", ovr16, 8'h00);
    check_output("ack_data_kept", data16, last_good);

    $display("[TB] slow instance: bad stop on 55 then break");
    apply_stimulus(8'h55, 1'b0, -1, 160);
    repeat (40) @(negedge clk);
    check_output("break_ferr", ferr16, 8'h01);
    check_output("break_busy", busy16, 8'h01);
    check_output("break_valid", valid16, 8'h00);
    check_output("break_data_kept", data16, last_good);
    pin16 = 1'b1;
    repeat (20) @(negedge clk);
    check_output("break_idle", busy16, 8'h00);
    check_output("break_no_valid", valid16, 8'h00);
    ack_pulse16();
    check_output("ferr_cleared", ferr16, 8'h00);

    $display("[TB] slow instance: 3-cycle glitch");
    repeat (4) @(negedge clk);
    pin16 = 1'b0;
    repeat (3) @(negedge clk);
    pin16 = 1'b1;
    @(negedge clk);
    check_output("glitch_busy", busy16, 8'h01);
    repeat (8) @(negedge clk);
    check_output("glitch_idle", busy16, 8'h00);
    check_output("glitch_valid", valid16, 8'h00);
    check_output("glitch_flags", {6'b0, ferr16, ovr16}, 8'h00);

    $display("[TB] slow instance: enable dropped during FF");
    apply_stimulus(8'hFF, 1'b1, -1, 84);
    check_output("abort_busy_before", busy16, 8'h01);
    ctrl16 = 8'h00;
    @(negedge clk);
    check_output("abort_busy", busy16, 8'h00);
    check_output("abort_flags", {6'b0, ferr16, ovr16}, 8'h00);
    check_output("abort_data_kept", data16, last_good);
    pin16 = 1'b1;
    repeat (100) @(negedge clk);
    ctrl16 = 8'h01;
    repeat (20) @(negedge clk);
    check_output("abort_no_valid", valid16, 8'h00);

    $display("[TB] slow instance: ack on stop-sample edge of 7E");
    exp_q.push_back(8'h81);
    apply_stimulus(8'h81, 1'b1, -1, 160);
    check_data("pre_ack_data", data16);
    check_output("pre_ack_valid", valid16, 8'h01);
    exp_q.push_back(8'h7E);
    apply_stimulus(8'h7E, 1'b1, 153, 160);
    pin16 = 1'b1;
    check_data("coinc_data", data16);
    check_output("coinc_valid", valid16, 8'h01);
    check_output("coinc_overrun", ovr16, 8'h00);
    check_output("coinc_ferr", ferr16, 8'h00);

    $display("[TB] reset during frame 12");
    apply_stimulus(8'h12, 1'b1, -1, 50);
    #2 reset = 1'b0;
    #1;
    check_output("async_data", data16, 8'h00);
    check_output("async_valid", valid16, 8'h00);
    check_output("async_busy", busy16, 8'h00);
    check_output("async_flags", {6'b0, ferr16, ovr16}, 8'h00);
    check_output("async_data1", data1, 8'h00);
    check_output("async_valid1", valid1, 8'h00);
    @(negedge clk);
    pin16 = 1'b1;
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check_output("post_reset_valid", valid16, 8'h00);
    check_output("post_reset_busy", busy16, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
